load_store_unit: RTL and testbench
==================================

# load_store_unit

Load/store unit downstream of the execute-stage ALU in the single-cycle RV32I core. The ALU result is the effective address. The block turns LB/LH/LW/LBU/LHU/SB/SH/SW into one word-aligned, byte-enabled transaction on a req/ack data-memory port, and returns sign- or zero-extended load data. It holds `busy` high to stall PC/regfile writeback until the access completes, faults or times out.

## Interface
- `TIMEOUT`, 255: max cycles in WAIT before abort (used only with `LSU_TIMEOUT_EN`).
- `clk` in 1: core clock; all state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req` in 1: instruction is load/store; held by core until `done`.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `uns` in 1: zero-extend load (funct3[2]).
- `addr` in 32: effective address (ALU `out`).
- `wdata` in 32: store data (rs2).
- `busy` out 1: stall core.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result, held until next load completes.
- `misalign` out 1: fault flag, valid with `done`.
- `timeout` out 1: abort flag, valid with `done`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32 ({addr[31:2],2'b00}), `mem_be` out 4, `mem_wdata` out 32.
- `mem_ack` in 1, `mem_rdata` in 32.

## Operation
- FSM states:
  - IDLE → WAIT: `req` and legal/aligned; latch addr, size, uns, we, and lane-aligned wdata/be.
  - IDLE → RESP: `req` and fault; no memory access.
  - WAIT → RESP: `mem_ack` sampled high, or timeout.
  - RESP → IDLE: unconditional.
- Fault conditions: size 11; half with addr[0]=1; word with addr[1:0]≠00.
- `busy` = (IDLE & `req`) | WAIT. It is combinational so the core stalls in the request cycle. `busy` is 0 in RESP.
- `req` is ignored in RESP, because the core still drives the same instruction then.
- `mem_req` = 1 exactly in WAIT. Address, be, we and wdata are stable throughout WAIT.
- Store lanes:
  - byte: be = 1<<addr[1:0], wdata = {4{b}}.
  - half: be = 0011 or 1100, wdata = {2{h}}.
  - word: be = 1111.
- Loads: select the lane by the latched addr[1:0]. Sign-extend from bit 7 or bit 15 unless `uns`. `rdata` updates on the ack edge.
- Stores, faults and timeouts leave `rdata` unchanged.
- `done` is 1 only in RESP. `misalign` and `timeout` are registered and valid only in RESP, otherwise 0.

## Timing
- Reset values: state IDLE, `rdata` 0, and 0 for `done`, `misalign`, `timeout`, `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`.
- Access latency: IDLE(req) → WAIT → RESP, i.e. `done` in cycle 2 with same-cycle ack. Each cycle without ack adds one cycle.
- Fault: `done` + `misalign` in cycle 1. `mem_req` never rises.
- Reset during WAIT: IDLE next edge and `mem_req` drops. A late `mem_ack` in IDLE/RESP is ignored.
- Back-to-back accesses: a new `req` is accepted only in IDLE, so minimum spacing is 3 cycles.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - counter cleared on WAIT entry, increments each WAIT cycle without ack;
  - reaching `TIMEOUT` forces RESP with `timeout`=1 and `mem_req` dropped;
  - an ack in the same cycle as the limit wins (normal completion).
- Undefined: no counter; WAIT lasts until ack. The `timeout` port remains, tied 0.

## Structure
- Package `lsu_pkg`:
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`;
  - FSM state enum (IDLE, WAIT, RESP).
- Sub-module `lsu_align`: purely combinational store lane steering and load extraction/extension. Inputs: size, uns, addr[1:0], data. Outputs: be, aligned wdata, extended rdata.
- FSM, registers and timeout counter live in `load_store_unit`.

## Test plan
- LW addr 0x100, ack 3 cycles after mem_req, mem_rdata 0xDEADBEEF → mem_addr 0x100, be 1111, `done` in cycle 5, `rdata`=0xDEADBEEF, `busy` high cycles 0–4.
- LB addr 0x203, mem_rdata 0x80xxxxxx → 0xFFFFFF80. LBU same → 0x00000080. LH addr 0x202, mem_rdata 0x8001xxxx → 0xFFFF8001.
- SB addr 0x11, wdata 0x000000A5 → be 0010, mem_wdata 0xA5A5A5A5, mem_we 1, `rdata` unchanged.
- LW addr 0x102 → `done`+`misalign` in cycle 1, no `mem_req`. SH addr 0x5 → same.
- `rst_n` low during WAIT → `mem_req` 0 next cycle. A subsequent `mem_ack` produces no `done`.
- With `LSU_TIMEOUT_EN`, TIMEOUT=4, no ack → `mem_req` drops and `done`+`timeout` occur in the cycle after 4 WAIT cycles.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and helpers for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  // An access faults when the size is illegal or the address is not
  // naturally aligned for the requested width.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_H:    bad = off[0];
      SZ_W:    bad = (off != 2'b00);
      SZ_X:    bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core-side and data-memory-side signal bundle of the LSU
interface load_store_unit_if;

  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misalign;
  logic        timeout;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Environment view: the core plus the data memory.
  modport master (
    output req, we, size, uns, addr, wdata, mem_ack, mem_rdata,
    input  busy, done, rdata, misalign, timeout,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  // LSU view.
  modport slave (
    input  req, we, size, uns, addr, wdata, mem_ack, mem_rdata,
    output busy, done, rdata, misalign, timeout,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational store lane steering and load extraction/extension
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Store side: replicate the operand across lanes and enable only the addressed bytes.
  always_comb begin
    be_o    = 4'b0000;
    wdata_o = data_i;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{data_i[7:0]}};
      end
      SZ_H: begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{data_i[15:0]}};
      end
      SZ_W: begin
        be_o    = 4'b1111;
      end
      default: begin
        be_o    = 4'b0000;
      end
    endcase
  end

  // Load side: pick the addressed lane, then sign- or zero-extend it.
  always_comb begin
    lane_b = 8'h00;
    case (off_i)
      2'd0:    lane_b = data_i[7:0];
      2'd1:    lane_b = data_i[15:8];
      2'd2:    lane_b = data_i[23:16];
      default: lane_b = data_i[31:24];
    endcase
    lane_h  = off_i[1] ? data_i[31:16] : data_i[15:0];
    rdata_o = data_i;
    case (size_i)
      SZ_B:    rdata_o = {{24{~uns_i & lane_b[7]}}, lane_b};
      SZ_H:    rdata_o = {{16{~uns_i & lane_h[15]}}, lane_h};
      default: rdata_o = data_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit FSM; LSU_TIMEOUT_EN enables the WAIT abort counter
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  lsu_state_e  state_q;
  logic [29:0] addr_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        mem_req_q;
  logic        done_q;
  logic        misalign_q;

  logic        in_idle;
  logic        fault;
  logic [1:0]  al_size;
  logic        al_uns;
  logic [1:0]  al_off;
  logic [31:0] al_data;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign in_idle = (state_q == IDLE);
  assign fault   = lsu_misaligned(bus.size, bus.addr[1:0]);

  // In IDLE the aligner steers the incoming store; in WAIT it extracts the
  // returning load using the latched attributes. The two uses never overlap.
  assign al_size = in_idle ? bus.size       : size_q;
  assign al_uns  = in_idle ? bus.uns        : uns_q;
  assign al_off  = in_idle ? bus.addr[1:0]  : off_q;
  assign al_data = in_idle ? bus.wdata      : bus.mem_rdata;

  lsu_align u_align (
    .size_i  (al_size),
    .uns_i   (al_uns),
    .off_i   (al_off),
    .data_i  (al_data),
    .be_o    (al_be),
    .wdata_o (al_wdata),
    .rdata_o (al_rdata)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
`endif

  // Access sequencer: IDLE accepts, WAIT holds the memory request, RESP reports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_req_q  <= 1'b0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            if (fault) begin
              state_q    <= RESP;
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              state_q   <= WAIT;
              mem_req_q <= 1'b1;
              addr_q    <= bus.addr[31:2];
              off_q     <= bus.addr[1:0];
              size_q    <= bus.size;
              uns_q     <= bus.uns;
              we_q      <= bus.we;
              be_q      <= al_be;
              wdata_q   <= al_wdata;
`ifdef LSU_TIMEOUT_EN
              cnt_q     <= '0;
`endif
            end
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            if (!we_q) begin
              rdata_q <= al_rdata;
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = (in_idle & bus.req) | (state_q == WAIT);
  assign bus.done      = done_q;
  assign bus.rdata     = rdata_q;
  assign bus.misalign  = misalign_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = {addr_q, 2'b00};
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

`ifdef LSU_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
  localparam bit TO_EN      = 1'b1;
  localparam int TB_TIMEOUT = 4;
`else
  localparam bit TO_EN      = 1'b0;
  localparam int TB_TIMEOUT = 255;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] exp_rdata;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_fault(input int size, input int off);
    return (size == 3) || (size == 1 && (off % 2) != 0) || (size == 2 && off != 0);
  endfunction

  function automatic logic [3:0] model_be(input int size, input int off);
    if (size == 0) return 4'(1 << off);
    if (size == 1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input int size, input logic [31:0] w);
    if (size == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (size == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input int size, input bit uns, input int off,
                                              input logic [31:0] m);
    int unsigned bits, v, mask;
    if (size == 2) return m;
    bits = (size == 0) ? 8 : 16;
    mask = (32'd1 << bits) - 1;
    v    = (m >> (8 * off)) & mask;
    if (!uns && ((v >> (bits - 1)) & 1) == 1) v = v | ~mask;
    return v;
  endfunction

  // One complete access; ack arrives d cycles after mem_req rises.
  task automatic do_access(input bit we, input int size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] mrdata, input int d);
    int  off;
    bit  to;
    int  n_wait;
    off = int'(addr[1:0]);
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.size  = 2'(size);
    bus.uns   = uns;
    bus.addr  = addr;
    bus.wdata = wdata;
    bus.mem_ack = 1'b0;
    #1;
    check("busy_req_cycle", bus.busy, 1);
    check("mem_req_cycle0", bus.mem_req, 0);
    if (model_fault(size, off)) begin
      @(negedge clk);
      check("fault_done", bus.done, 1);
      check("fault_misalign", bus.misalign, 1);
      check("fault_mem_req", bus.mem_req, 0);
      check("fault_busy", bus.busy, 0);
      check("fault_rdata", bus.rdata, exp_rdata);
      bus.req = 1'b0;
    end else begin
      to     = TO_EN && (d >= TB_TIMEOUT);
      n_wait = to ? TB_TIMEOUT : d + 1;
      for (int k = 0; k < n_wait; k++) begin
        @(negedge clk);
        check("wait_mem_req", bus.mem_req, 1);
        check("wait_busy", bus.busy, 1);
        check("wait_done", bus.done, 0);
        check("wait_addr", bus.mem_addr, addr & 32'hFFFF_FFFC);
        check("wait_we", bus.mem_we, we);
        check("wait_be", bus.mem_be, model_be(size, off));
        if (we) check("wait_wdata", bus.mem_wdata, model_wdata(size, wdata));
        bus.mem_ack   = (k == d);
        bus.mem_rdata = (k == d) ? mrdata : $urandom;
      end
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (!we && !to) exp_rdata = model_load(size, uns, off, mrdata);
      check("resp_done", bus.done, 1);
      check("resp_misalign", bus.misalign, 0);
      check("resp_timeout", bus.timeout, 32'(to));
      check("resp_mem_req", bus.mem_req, 0);
      check("resp_busy", bus.busy, 0);
      check("resp_rdata", bus.rdata, exp_rdata);
      bus.req = 1'b0;
    end
    @(negedge clk);
    check("idle_done", bus.done, 0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    exp_rdata     = 32'h0;
    rst_n         = 1'b0;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.size      = 2'b00;
    bus.uns       = 1'b0;
    bus.addr      = 32'h0;
    bus.wdata     = 32'h0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_done", bus.done, 0);
    check("rst_misalign", bus.misalign, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_be", bus.mem_be, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    do_access(1'b0, 2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
    do_access(1'b0, 0, 1'b0, 32'h203, 32'h0, 32'h8012_3456, 0);
    do_access(1'b0, 0, 1'b1, 32'h203, 32'h0, 32'h8012_3456, 1);
    do_access(1'b0, 1, 1'b0, 32'h202, 32'h0, 32'h8001_1234, 0);
    do_access(1'b1, 0, 1'b0, 32'h11, 32'h0000_00A5, 32'h1357_9BDF, 2);
    do_access(1'b1, 1, 1'b0, 32'h12, 32'h1234_C3D4, 32'h0, 0);
    do_access(1'b1, 2, 1'b0, 32'h44, 32'hCAFE_F00D, 32'h0, 1);
    do_access(1'b0, 2, 1'b0, 32'h102, 32'h0, 32'h0, 0);
    do_access(1'b1, 1, 1'b0, 32'h5, 32'h0, 32'h0, 0);
    do_access(1'b0, 3, 1'b0, 32'h8, 32'h0, 32'h0, 0);
    if (TO_EN) begin
      do_access(1'b0, 2, 1'b0, 32'h300, 32'h0, 32'h1111_2222, TB_TIMEOUT);
      do_access(1'b0, 2, 1'b0, 32'h304, 32'h0, 32'h3333_4444, TB_TIMEOUT - 1);
    end

    // Reset in WAIT aborts the access; a late ack must not complete anything.
    @(negedge clk);
    bus.req  = 1'b1;
    bus.we   = 1'b0;
    bus.size = 2'b10;
    bus.addr = 32'h40;
    @(negedge clk);
    check("rstwait_mem_req_before", bus.mem_req, 1);
    rst_n   = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);
    check("rstwait_mem_req_after", bus.mem_req, 0);
    check("rstwait_busy", bus.busy, 0);
    rst_n       = 1'b1;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check("late_ack_done0", bus.done, 0);
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_done1", bus.done, 0);
    exp_rdata = 32'h0;
    check("rstwait_rdata", bus.rdata, exp_rdata);

    for (int i = 0; i < 60; i++) begin
      do_access(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom,
                int'($urandom_range(0, TO_EN ? TB_TIMEOUT + 1 : 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
